// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmitter.
//   uart_state_e  - 3-bit FSM state encoding (IDLE/ARM/START/DATA/PARITY/STOP)
//   DATA_BITS     - data bits per frame
//   PARITY_BITS   - 1 when UART_TX_PARITY_EN is defined, else 0
//   FRAME_LEN_MIN/FRAME_LEN_MAX, frame_len() - frame lengths in bit intervals
// Optional feature macro: UART_TX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd5
  } uart_state_e;

  localparam int unsigned DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif

  // Shortest frame (no parity, one stop bit) and longest (parity, two stop bits).
  localparam int unsigned FRAME_LEN_MIN = 1 + DATA_BITS + 1;
  localparam int unsigned FRAME_LEN_MAX = 1 + DATA_BITS + 1 + 2;

  // Bit intervals in one frame for this build: start + data + parity + stop.
  function automatic int unsigned frame_len(input int unsigned stop_bits);
    return 1 + DATA_BITS + PARITY_BITS + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// uart_tx: byte-serial UART transmitter, MSB first, one bit per baud_pulse.
// Frame: start(0), 8 data bits MSB first, optional parity, STOP_BITS stop bits (1).
// Parameters:
//   STOP_BITS  - stop bits per frame (1 or 2)
//   PARITY_ODD - parity sense when parity is compiled in (0 even, 1 odd)
// Optional feature macro: UART_TX_PARITY_EN (adds the parity bit and PARITY state).
// Ports:
//   clk        - system clock
//   rst_n      - asynchronous active-low reset
//   baud_pulse - one-clk-wide bit-period strobe
//   byte_in    - byte to send, sampled on accept
//   valid_in   - upstream holds a byte
//   ready_out  - high only in IDLE; accept = valid_in && ready_out
//   tx         - registered serial line, idles high
//   busy       - high while a frame is in progress
//   done_out   - one-cycle pulse on the cycle the FSM re-enters IDLE
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_pulse,
  input  logic [7:0] byte_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx,
  output logic       busy,
  output logic       done_out
);

  if (STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_tx: STOP_BITS must be 1 or 2 and PARITY_ODD must be 0 or 1");
  end

  // Value of the stop counter on the final stop bit.
  localparam logic StopLast = (STOP_BITS == 2);

  uart_state_e state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        stop_cnt_q, stop_cnt_d;
  logic        tx_q, tx_d;
  logic        done_q, done_d;
  logic        accept;

`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  assign accept = valid_in && (state_q == IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = ARM;
      ARM:   if (baud_pulse) state_d = START;
      START: if (baud_pulse) state_d = DATA;
      DATA: begin
        if (baud_pulse && bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (baud_pulse) state_d = STOP;
`endif
      STOP:  if (baud_pulse && stop_cnt_q == StopLast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: shift register, counters and parity.
  always_comb begin
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d    = byte_in;
          bit_cnt_d  = 3'd0;
          stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d   = (^byte_in) ^ (PARITY_ODD != 0);
`endif
        end
      end
      DATA: begin
        if (baud_pulse) begin
          shreg_d   = {shreg_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 3'd1;  // wraps to 0 after the 8th bit
        end
      end
      STOP: begin
        if (baud_pulse) begin
          stop_cnt_d = (stop_cnt_q == StopLast) ? 1'b0 : ~stop_cnt_q;
        end
      end
      default: ;
    endcase
  end

  // Output logic: tx is registered from the next state so each bit appears on
  // the clock that enters its state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shreg_d[7];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = parity_q;
`endif
      default: tx_d = 1'b1;
    endcase
    done_d = (state_d == IDLE) && (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q    <= 8'h00;
      bit_cnt_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign ready_out = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign tx        = tx_q;
  assign done_out  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
// Two instances: u_dut0 (STOP_BITS=1, even parity) and u_dut1 (STOP_BITS=2, odd parity).
// Expected frames come from a queue-based frame builder or hand-computed table constants.
module tb_uart_tx;
  import uart_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       baud[2];
  logic [7:0] byte_in[2];
  logic       valid[2];
  logic       ready[2];
  logic       tx[2];
  logic       busy[2];
  logic       done[2];

  uart_tx #(.STOP_BITS(1), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .baud_pulse(baud[0]), .byte_in(byte_in[0]),
    .valid_in(valid[0]), .ready_out(ready[0]), .tx(tx[0]), .busy(busy[0]),
    .done_out(done[0])
  );

  uart_tx #(.STOP_BITS(2), .PARITY_ODD(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .baud_pulse(baud[1]), .byte_in(byte_in[1]),
    .valid_in(valid[1]), .ready_out(ready[1]), .tx(tx[1]), .busy(busy[1]),
    .done_out(done[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Frame as sent on the line, element 0 first.
  function automatic void model_frame(input logic [7:0] b, input int d,
                                      output logic [FRAME_LEN_MAX-1:0] f, output int len);
    logic q[$];
    q.push_back(1'b0);
    for (int i = 7; i >= 0; i--) q.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    q.push_back((^b) ^ (d == 1));
`endif
    for (int i = 0; i < ((d == 1) ? 2 : 1); i++) q.push_back(1'b1);
    f = '0;
    foreach (q[i]) f[i] = q[i];
    len = q.size();
  endfunction

  // Sends one byte starting at a negedge where the DUT is ready; ends at the
  // negedge of the done cycle (or one cycle later when not chaining).
  task automatic run_frame(input int d, input logic [7:0] b, input int period,
                           input bit tied, input bit chain, input logic [7:0] nb,
                           input bit poke, input bit use_exp,
                           input logic [FRAME_LEN_MAX-1:0] exp_tab, input string tag);
    logic [FRAME_LEN_MAX-1:0] ef, got;
    int  len;
    int  herr;
    logic cur;
    model_frame(b, d, ef, len);
    if (use_exp) ef = exp_tab;
    byte_in[d] = b;
    valid[d]   = 1'b1;
    baud[d]    = tied;
    check({tag, " ready_at_accept"}, 32'(ready[d]), 32'd1);
    @(posedge clk); #1;
    got  = '0;
    herr = 0;
    for (int j = 1; j <= len + 1; j++) begin
      for (int c = 0; c < period; c++) begin
        @(negedge clk);
        cur = (j == 1) ? 1'b1 : ef[j-2];
        if (tx[d] !== cur || ready[d] !== 1'b0 || busy[d] !== 1'b1 || done[d] !== 1'b0)
          herr++;
        if (chain) begin
          byte_in[d] = nb;
          valid[d]   = 1'b1;
        end else begin
          valid[d]   = poke && (j == 5) && (c == 0);
          byte_in[d] = valid[d] ? ~b : 8'($urandom);
        end
        baud[d] = tied || (c == period - 1);
      end
      @(posedge clk); #1;
      if (j <= len) got[j-1] = tx[d];
    end
    check({tag, " frame"}, 32'(got), 32'(ef));
    check({tag, " hold_errors"}, 32'(herr), 32'd0);
    @(negedge clk);
    check({tag, " done_ready_busy_tx"}, {28'd0, done[d], ready[d], busy[d], tx[d]}, 32'b1101);
    baud[d] = 1'b0;
    if (!chain) begin
      valid[d] = 1'b0;
      @(negedge clk);
      check({tag, " done_single"}, {30'd0, done[d], ready[d]}, 32'b01);
    end
  endtask

  typedef struct {
    int         d;
    logic [7:0] b;
    int         period;
    bit         tied;
    bit         chain;
    bit         poke;
    bit         use_exp;
    logic [FRAME_LEN_MAX-1:0] exp_f;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic [7:0] rb;
    // Hand-computed frames, bit 0 = start bit.
`ifdef UART_TX_PARITY_EN
    vt[0] = '{0, 8'hA5, 16, 1'b0, 1'b0, 1'b0, 1'b1, 12'h54A};
    vt[1] = '{0, 8'h5A, 1,  1'b1, 1'b0, 1'b0, 1'b1, 12'h4B4};
    vt[5] = '{1, 8'hA5, 3,  1'b0, 1'b0, 1'b0, 1'b1, 12'hF4A};
`else
    vt[0] = '{0, 8'hA5, 16, 1'b0, 1'b0, 1'b0, 1'b1, 12'h34A};
    vt[1] = '{0, 8'h5A, 1,  1'b1, 1'b0, 1'b0, 1'b1, 12'h2B4};
    vt[5] = '{1, 8'hA5, 3,  1'b0, 1'b0, 1'b0, 1'b1, 12'h74A};
`endif
    vt[2] = '{1, 8'h00, 5, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000};
    vt[3] = '{1, 8'hFF, 5, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
    vt[4] = '{0, 8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000};

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      baud[i] = 1'b0; byte_in[i] = 8'h00; valid[i] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      check($sformatf("reset_outputs_dut%0d", i),
            {28'd0, tx[i], busy[i], done[i], ready[i]}, 32'b1001);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vt[i])
      run_frame(vt[i].d, vt[i].b, vt[i].period, vt[i].tied, vt[i].chain,
                (i + 1 < 6) ? vt[i+1].b : 8'h00, vt[i].poke, vt[i].use_exp,
                vt[i].exp_f, $sformatf("vec%0d", i));

    // Reset in the middle of DATA for 0x3C: three pulses put bit 6 on the line.
    rb = 8'h3C;
    byte_in[0] = rb;
    valid[0]   = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      valid[0] = 1'b0;
      baud[0]  = (k % 4 == 3);
    end
    @(negedge clk);
    baud[0] = 1'b0;
    check("mid_data_bit6", 32'(tx[0]), 32'(rb[6]));
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {28'd0, tx[0], busy[0], done[0], ready[0]}, 32'b1001);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", {30'd0, busy[0], ready[0]}, 32'b01);
    run_frame(0, 8'h81, 4, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, '0, "post_reset_81");

    // Randomized frames against the frame builder.
    for (int i = 0; i < 10; i++) begin
      int d, per;
      bit td;
      d   = $urandom_range(0, 1);
      rb  = 8'($urandom);
      per = $urandom_range(1, 6);
      td  = (per == 1) && ($urandom_range(0, 1) == 1);
      run_frame(d, rb, per, td, 1'b0, 8'h00, ($urandom_range(0, 1) == 1), 1'b0, '0,
                $sformatf("rand%0d_d%0d_%02h", i, d, rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
